// File: rtl/b2r_row_serializer.sv
// Row FIFO between the block-to-row converter and a narrow valid/ready sink.
// Each buffered row is emitted as COL/BEAT_ELEMS beats, with row-end and matrix-last flags.
module b2r_row_serializer #(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned COL        = 64,
    parameter int unsigned ROW        = 256,
    parameter int unsigned BEAT_ELEMS = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic                          in_valid,
    input  logic                          in_last,
    input  logic [WIDTH*COL-1:0]          in_data,
    output logic                          in_ready,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [WIDTH*BEAT_ELEMS-1:0]   out_data,
    output logic                          out_row_end,
    output logic                          out_last,
    output logic                          overflow,
    output logic                          done
);

    localparam int unsigned BEATS  = COL / BEAT_ELEMS;
    localparam int unsigned BW     = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned PW     = $clog2(FIFO_DEPTH);
    localparam int unsigned CW     = PW + 1;
    localparam int unsigned RW     = $clog2(ROW + 1);
    localparam int unsigned DW     = WIDTH * COL;
    localparam int unsigned BEAT_W = WIDTH * BEAT_ELEMS;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e          state_q, state_d;
    logic [DW:0]     mem_q [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [BW-1:0]   beat_cnt_q, beat_cnt_d;
    logic [RW-1:0]   rows_out_q, rows_out_d;
    logic            overflow_q, overflow_d;

    logic [DW:0]     head;
    logic            full, last_beat, push, fire, pop;

    assign head      = mem_q[rd_ptr_q];
    assign full      = (count_q == CW'(FIFO_DEPTH));
    assign last_beat = (beat_cnt_q == BW'(BEATS - 1));

    always_comb begin
        in_ready    = (state_q == RUN) && en && !full;
        out_valid   = (state_q == RUN) && (count_q != '0);
        out_data    = out_valid ? head[int'(beat_cnt_q)*BEAT_W +: BEAT_W] : '0;
        out_row_end = out_valid && last_beat;
        out_last    = out_row_end && head[DW];
        overflow    = overflow_q;
        done        = (state_q == DONE);
        push        = in_valid && in_ready;
        fire        = out_valid && out_ready;
        pop         = fire && last_beat;
    end

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        beat_cnt_d = beat_cnt_q;
        rows_out_d = rows_out_q;
        overflow_d = overflow_q;
        case (state_q)
            IDLE: if (en) state_d = RUN;
            RUN: begin
                if (push) wr_ptr_d = wr_ptr_q + 1'b1;
                if (fire) beat_cnt_d = last_beat ? '0 : beat_cnt_q + 1'b1;
                if (pop) begin
                    rd_ptr_d = rd_ptr_q + 1'b1;
                    if (rows_out_q != RW'(ROW)) rows_out_d = rows_out_q + 1'b1;
                    if (head[DW]) state_d = DONE;
                end
                if (push && !pop)      count_d = count_q + 1'b1;
                else if (pop && !push) count_d = count_q - 1'b1;
                // Fullness uses the pre-edge count, so a same-cycle pop cannot rescue the row.
                if (in_valid && en && full) overflow_d = 1'b1;
            end
            DONE: begin
                if (!en) begin
                    state_d    = IDLE;
                    wr_ptr_d   = '0;
                    rd_ptr_d   = '0;
                    count_d    = '0;
                    beat_cnt_d = '0;
                    rows_out_d = '0;
                    overflow_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            beat_cnt_q <= '0;
            rows_out_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            beat_cnt_q <= beat_cnt_d;
            rows_out_q <= rows_out_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {in_last, in_data};
    end

endmodule

// File: tb/tb_b2r_row_serializer.sv
// Scoreboard and table-driven bench for b2r_row_serializer with default parameters.
module tb_b2r_row_serializer;

    localparam int WIDTH = 16;
    localparam int COL   = 64;
    localparam int BE    = 8;
    localparam int BEATS = COL / BE;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   en = 1'b0;
    logic                   in_valid = 1'b0;
    logic                   in_last = 1'b0;
    logic [WIDTH*COL-1:0]   in_data = '0;
    logic                   in_ready;
    logic                   out_valid;
    logic                   out_ready = 1'b0;
    logic [WIDTH*BE-1:0]    out_data;
    logic                   out_row_end;
    logic                   out_last;
    logic                   overflow;
    logic                   done;

    b2r_row_serializer #(.WIDTH(WIDTH), .COL(COL), .ROW(256), .BEAT_ELEMS(BE), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_last(in_last),
        .in_data(in_data), .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_row_end(out_row_end), .out_last(out_last),
        .overflow(overflow), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [WIDTH*BE-1:0] data;
        logic                re;
        logic                la;
    } beat_t;

    typedef struct {
        bit iv;
        bit il;
        int base;
        bit e_in_ready;
        bit e_out_valid;
        bit e_ovf;
    } vec_t;

    beat_t sb[$];
    int    n_cmp = 0;
    int    n_err = 0;
    int    mon_beats = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [WIDTH*COL-1:0] mkrow(input int base);
        logic [WIDTH*COL-1:0] r;
        for (int i = 0; i < COL; i++) r[i*WIDTH +: WIDTH] = 16'(base + i);
        return r;
    endfunction

    task automatic push_row(input int base, input bit last);
        beat_t e;
        for (int k = 0; k < BEATS; k++) begin
            for (int j = 0; j < BE; j++) e.data[j*WIDTH +: WIDTH] = 16'(base + k*BE + j);
            e.re = (k == BEATS-1);
            e.la = (k == BEATS-1) && last;
            sb.push_back(e);
        end
    endtask

    task automatic drive_row(input int base, input bit last, input bit accept);
        in_valid = 1'b1;
        in_last  = last;
        in_data  = mkrow(base);
        if (accept) push_row(base, last);
    endtask

    task automatic send_row(input int base, input bit last, input bit accept);
        drive_row(base, last, accept);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic monitor();
        logic [WIDTH*BE-1:0] hd;
        logic hre, hla;
        bit hold;
        beat_t e;
        hold = 0; hd = '0; hre = 0; hla = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold = 0;
            end else begin
                if (hold && out_valid) begin
                    chk("stall_data", out_data, hd);
                    chk("stall_row_end", out_row_end, hre);
                    chk("stall_last", out_last, hla);
                end
                hold = out_valid && !out_ready;
                hd = out_data; hre = out_row_end; hla = out_last;
                if (out_valid && out_ready) begin
                    mon_beats++;
                    if (sb.size() == 0) begin
                        chk("unexpected_beat", out_valid, 1'b0);
                    end else begin
                        e = sb.pop_front();
                        chk("beat_data", out_data, e.data);
                        chk("beat_row_end", out_row_end, e.re);
                        chk("beat_last", out_last, e.la);
                    end
                end
            end
        end
    endtask

    task automatic start_run();
        en = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic wait_done(input string nm);
        for (int i = 0; i < 300; i++) begin
            if (done) break;
            @(posedge clk); #1;
        end
        chk({nm, "_done"}, done, 1'b1);
        chk({nm, "_sb_empty"}, sb.size(), 0);
    endtask

    task automatic end_run(input string nm);
        en = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk({nm, "_idle_done"}, done, 1'b0);
        chk({nm, "_idle_ovf"}, overflow, 1'b0);
        chk({nm, "_idle_valid"}, out_valid, 1'b0);
        @(posedge clk); #1;
    endtask

    vec_t tbl[6];
    int   b0;

    initial begin
        // fill: 4 rows with sink stalled, 5th dropped
        tbl[0] = '{1, 0, 100, 1, 0, 0};
        tbl[1] = '{1, 0, 200, 1, 1, 0};
        tbl[2] = '{1, 0, 300, 1, 1, 0};
        tbl[3] = '{1, 1, 400, 1, 1, 0};
        tbl[4] = '{1, 0, 500, 0, 1, 0};
        tbl[5] = '{0, 0, 0,   0, 1, 1};

        fork monitor(); join_none

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_row_end", out_row_end, 1'b0);
        chk("rst_last", out_last, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_overflow", overflow, 1'b0);
        chk("rst_out_data", out_data, '0);
        rst = 1'b0;
        @(posedge clk); #1;

        // in_valid while IDLE is ignored
        drive_row(900, 1, 0);
        repeat (2) @(posedge clk);
        #1 in_valid = 1'b0;
        start_run();
        @(negedge clk);
        chk("idle_ignored_valid", out_valid, 1'b0);
        chk("idle_ignored_ovf", overflow, 1'b0);
        chk("run_in_ready", in_ready, 1'b1);
        @(posedge clk); #1;

        // single row, full-rate sink
        out_ready = 1'b1;
        send_row(0, 1, 1);
        for (int k = 0; k < BEATS; k++) begin
            @(negedge clk);
            chk("t1_valid", out_valid, 1'b1);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("t1_done", done, 1'b1);
        chk("t1_valid_off", out_valid, 1'b0);
        chk("t1_in_ready_off", in_ready, 1'b0);
        chk("t1_sb_empty", sb.size(), 0);
        @(posedge clk); #1;
        end_run("t1");

        // table: fill FIFO while stalled, overflow on 5th row
        start_run();
        out_ready = 1'b0;
        for (int s = 0; s < 6; s++) begin
            in_valid = tbl[s].iv;
            in_last  = tbl[s].il;
            in_data  = mkrow(tbl[s].base);
            if (tbl[s].iv && tbl[s].e_in_ready) push_row(tbl[s].base, tbl[s].il);
            @(negedge clk);
            chk("tbl_in_ready", in_ready, tbl[s].e_in_ready);
            chk("tbl_out_valid", out_valid, tbl[s].e_out_valid);
            chk("tbl_overflow", overflow, tbl[s].e_ovf);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        b0 = mon_beats;
        out_ready = 1'b1;
        wait_done("t2");
        chk("t2_beats", mon_beats - b0, 4*BEATS);
        chk("t2_ovf_sticky", overflow, 1'b1);
        end_run("t2");

        // toggling sink: holds during stalls, no skip/duplicate
        start_run();
        out_ready = 1'b0;
        send_row(0, 1, 1);
        b0 = mon_beats;
        for (int i = 0; i < 60 && !done; i++) begin
            out_ready = ~out_ready;
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        wait_done("t3");
        chk("t3_beats", mon_beats - b0, BEATS);
        end_run("t3");

        // full FIFO, write in the cycle the head pops -> dropped
        start_run();
        out_ready = 1'b0;
        send_row(1000, 0, 1);
        send_row(2000, 0, 1);
        send_row(3000, 0, 1);
        send_row(4000, 1, 1);
        out_ready = 1'b1;
        repeat (BEATS-1) begin @(posedge clk); #1; end
        drive_row(5000, 0, 0);
        @(negedge clk);
        chk("t4_pop_row_end", out_row_end, 1'b1);
        chk("t4_full_in_ready", in_ready, 1'b0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("t4_overflow", overflow, 1'b1);
        chk("t4_in_ready_after_pop", in_ready, 1'b1);
        wait_done("t4");
        end_run("t4");

        // count=3: write and pop coincide, pointers wrap
        start_run();
        out_ready = 1'b0;
        send_row(10, 0, 1);
        send_row(20, 0, 1);
        send_row(30, 0, 1);
        out_ready = 1'b1;
        repeat (BEATS-1) begin @(posedge clk); #1; end
        drive_row(40, 0, 1);
        @(negedge clk);
        chk("t5_in_ready_c3", in_ready, 1'b1);
        chk("t5_pop_row_end", out_row_end, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("t5_count_held", in_ready, 1'b1);
        repeat (BEATS-1) begin @(posedge clk); #1; end
        drive_row(50, 1, 1);
        @(negedge clk);
        chk("t5_in_ready_c3b", in_ready, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("t5_count_held_b", in_ready, 1'b1);
        chk("t5_no_ovf", overflow, 1'b0);
        wait_done("t5");
        end_run("t5");

        // async reset after beat 3 of row 2
        start_run();
        out_ready = 1'b0;
        send_row(600, 0, 1);
        send_row(650, 0, 1);
        b0 = mon_beats;
        out_ready = 1'b1;
        for (int i = 0; i < 100 && (mon_beats - b0) < BEATS + 4; i++) begin
            @(posedge clk); #1;
        end
        chk("t6_beats_before_rst", mon_beats - b0, BEATS + 4);
        en = 1'b0;
        rst = 1'b1;
        #1;
        chk("t6_rst_valid", out_valid, 1'b0);
        chk("t6_rst_in_ready", in_ready, 1'b0);
        chk("t6_rst_row_end", out_row_end, 1'b0);
        chk("t6_rst_last", out_last, 1'b0);
        chk("t6_rst_done", done, 1'b0);
        chk("t6_rst_out_data", out_data, '0);
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        start_run();
        @(negedge clk);
        chk("t6_fifo_empty", out_valid, 1'b0);
        @(posedge clk); #1;
        send_row(700, 1, 1);
        wait_done("t6");
        end_run("t6");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
